// File: rtl/cp_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp_mon_pkg
// Description : Shared FSM state encoding and default start code for the
//               checkpoint sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package cp_mon_pkg;

    localparam int unsigned CP_MON_STATE_W = 3;

    typedef logic [CP_MON_STATE_W-1:0] cp_state_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_TRACK      = 3'd2;
    localparam logic [2:0] ST_PASS       = 3'd3;
    localparam logic [2:0] ST_FAIL       = 3'd4;

    localparam logic [15:0] CP_MON_START_CODE = 16'hAAAA;

endpackage
`default_nettype wire

// File: rtl/cp_stable_filter.sv
`default_nettype none
// ============================================================================
// Module      : cp_stable_filter
// Description : Emits a one-cycle event when the input has held one value for
//               STABLE_CYCLES consecutive samples; once per stable episode.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_stable_filter #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             event_o
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    run_q, run_d;
    logic             event_q, event_d;
    logic             w_restart;

    // A zero run length marks "no history", so the first sample after reset
    // always starts a fresh run.
    always_comb begin
        value_d   = value_q;
        run_d     = run_q;
        w_restart = (run_q == '0) || (data_i != value_q);
        if (w_restart) begin
            value_d = data_i;
            run_d   = C_ONE;
        end else if (run_q != C_STABLE) begin
            run_d = run_q + C_ONE;
        end
        event_d = (run_d == C_STABLE) && (w_restart || (run_q != C_STABLE));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
            run_q   <= '0;
            event_q <= 1'b0;
        end else begin
            value_q <= value_d;
            run_q   <= run_d;
            event_q <= event_d;
        end
    end

    assign value_o = value_q;
    assign event_o = event_q;

endmodule
`default_nettype wire

// File: rtl/checkpoint_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module      : checkpoint_seq_monitor
// Description : Watches a checkpoint bus for START_CODE followed by NUM_CP
//               expected codes; reports pass, fail or timeout.
//               Optional macro CP_MON_STRICT_EN fails on unexpected codes.
// Revision    : 1.0 - initial release
// ============================================================================
module checkpoint_seq_monitor
    import cp_mon_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               NUM_CP         = 4,
    parameter logic [WIDTH-1:0] START_CODE     = WIDTH'(CP_MON_START_CODE),
    parameter int               STABLE_CYCLES  = 4,
    parameter int unsigned      TIMEOUT_CYCLES = 200000
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         enable,
    input  logic [WIDTH-1:0]             checkbits,
    input  logic [NUM_CP*WIDTH-1:0]      cp_table,
    output logic                         started,
    output logic [$clog2(NUM_CP+1)-1:0]  cp_index,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [31:0]                  elapsed
);

    localparam int            IW         = $clog2(NUM_CP + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CP - 1);
    localparam logic [31:0]   TIMEOUT_32 = 32'(TIMEOUT_CYCLES);

    cp_state_t        state_q, state_d;
    logic             started_q, started_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      elapsed_q, elapsed_d;
`ifdef CP_MON_STRICT_EN
    logic [WIDTH-1:0] last_q, last_d;
`endif

    logic [WIDTH-1:0] w_value;
    logic             w_event;
    logic [WIDTH-1:0] w_expected;
    logic [31:0]      w_elapsed_inc;
    logic             w_timeout_hit;

    cp_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .data_i  (checkbits),
        .value_o (w_value),
        .event_o (w_event)
    );

    always_comb begin
        w_expected = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (idx_q == IW'(i)) begin
                w_expected = cp_table[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_elapsed_inc = (elapsed_q == 32'hFFFF_FFFF) ? elapsed_q : elapsed_q + 32'd1;
    assign w_timeout_hit = (w_elapsed_inc >= TIMEOUT_32);

    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        elapsed_d = elapsed_q;
`ifdef CP_MON_STRICT_EN
        last_d    = last_q;
`endif
        if (!enable) begin
            state_d   = ST_IDLE;
            started_d = 1'b0;
            idx_d     = '0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            elapsed_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT_START;
                    elapsed_d = '0;
                end
                ST_WAIT_START: begin
                    elapsed_d = w_elapsed_inc;
                    if (w_timeout_hit) begin
                        state_d   = ST_FAIL;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else if (w_event && (w_value == START_CODE)) begin
                        state_d   = ST_TRACK;
                        started_d = 1'b1;
`ifdef CP_MON_STRICT_EN
                        last_d    = START_CODE;
`endif
                    end
                end
                ST_TRACK: begin
                    elapsed_d = w_elapsed_inc;
                    // The budget check wins over any event landing on the same edge.
                    if (w_timeout_hit) begin
                        state_d   = ST_FAIL;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else if (w_event) begin
                        if (w_value == w_expected) begin
                            idx_d = idx_q + IW'(1);
`ifdef CP_MON_STRICT_EN
                            last_d = w_value;
`endif
                            if (idx_q == LAST_IDX) begin
                                state_d = ST_PASS;
                                pass_d  = 1'b1;
                            end
                        end
`ifdef CP_MON_STRICT_EN
                        else if ((w_value != START_CODE) && (w_value != last_q)) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end
`endif
                    end
                end
                ST_PASS, ST_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            started_q <= 1'b0;
            idx_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            elapsed_q <= '0;
`ifdef CP_MON_STRICT_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            elapsed_q <= elapsed_d;
`ifdef CP_MON_STRICT_EN
            last_q    <= last_d;
`endif
        end
    end

    assign started  = started_q;
    assign cp_index = idx_q;
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign timeout  = timeout_q;
    assign elapsed  = elapsed_q;

endmodule
`default_nettype wire

// File: doc/checkpoint_seq_monitor.md
CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of the monitored checkpoint bus.
REQ-002 SHALL have parameter NUM_CP, default 4, range 1..16, number of expected checkpoints after the start code.
REQ-003 SHALL have parameter START_CODE, default 16'hAAAA, code that arms tracking.
REQ-004 SHALL have parameter STABLE_CYCLES, default 4, minimum 1, consecutive unchanged cycles needed to qualify a value.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 200000, cycle budget measured from enable.
REQ-006 SHALL have port wb_clk_i, input, 1, the single clock.
REQ-007 SHALL have port wb_rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1, run request; low forces IDLE.
REQ-009 SHALL have port checkbits, input, WIDTH, observed checkpoint bus.
REQ-010 SHALL have port cp_table, input, NUM_CP*WIDTH, expected codes; entry i is at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port started, output, 1, START_CODE seen.
REQ-012 SHALL have port cp_index, output, $clog2(NUM_CP+1), count of checkpoints matched so far.
REQ-013 SHALL have ports pass, fail and timeout, outputs, 1 each; these are the sticky result flags.
REQ-014 SHALL have port elapsed, output, 32, saturating cycle count since enable.

Function
REQ-015 SHALL qualify a value when checkbits has held the same value for STABLE_CYCLES consecutive cycles; each qualified value produces a one-cycle event.
REQ-016 SHALL produce exactly one event per distinct stable value, and SHALL produce no new event while the value is unchanged.
REQ-017 SHALL implement the FSM states IDLE, WAIT_START, TRACK, PASS and FAIL.
REQ-018 SHALL move IDLE->WAIT_START on the cycle after enable is sampled high; elapsed clears to 0 on entry.
REQ-019 SHALL move WAIT_START->TRACK on a START_CODE event, setting started the same cycle.
REQ-020 SHALL increment cp_index in TRACK on an event equal to cp_table[cp_index].
REQ-021 SHALL enter PASS and set pass when the event matching entry NUM_CP-1 occurs.
REQ-022 SHALL make the match of REQ-020 take priority when a TRACK event equals both START_CODE and the expected entry.
REQ-023 SHALL enter FAIL and set timeout when elapsed reaches TIMEOUT_CYCLES in WAIT_START or TRACK; a match event in that same cycle is ignored.
REQ-024 SHALL hold PASS and FAIL until enable goes low or reset; elapsed freezes in both states.
REQ-025 SHALL return to IDLE on the next cycle when enable is low in any state, clearing all outputs.
REQ-026 SHALL stop elapsed at 32'hFFFFFFFF without wrapping.

Reset
REQ-027 SHALL, on wb_rst_i high at a clock edge, force state IDLE and set started, cp_index, pass, fail, timeout and elapsed to 0.
REQ-028 SHALL clear the stability filter history on reset, so the first qualification after reset needs a full STABLE_CYCLES cycles.
REQ-029 SHALL abandon any run in progress on reset mid-run, without setting any flag.

Configuration
REQ-030 SHALL, with macro CP_MON_STRICT_EN defined, enter FAIL (timeout=0) on a TRACK event that is neither START_CODE, nor cp_table[cp_index], nor the most recently matched code.
REQ-031 SHALL, without CP_MON_STRICT_EN, ignore unmatched TRACK events; fail is then reachable only via timeout.

Structure
REQ-032 SHALL take the FSM state enumeration and the default START_CODE constant from the shared package cp_mon_pkg.
REQ-033 SHALL implement the stability filter as the sub-module cp_stable_filter, with parameters WIDTH and STABLE_CYCLES, outputs a value and a one-cycle event pulse.

Verification
REQ-034 SHALL verify the nominal run: with table {AB40,AB41,AB42,AB43} and each value held 10 cycles after AAAA -> cp_index steps 1..4, pass=1, fail=0.
REQ-035 SHALL verify glitch rejection: a 3-cycle AB40 pulse with STABLE_CYCLES=4 -> no event and cp_index stays 0; a 4-cycle hold -> cp_index=1.
REQ-036 SHALL verify timeout: TIMEOUT_CYCLES=1000 with no AAAA presented -> fail=1 and timeout=1 when elapsed=1000, started=0.
REQ-037 SHALL verify strict mode: with CP_MON_STRICT_EN, AAAA then BEEF held -> fail=1, timeout=0; without the macro -> no flag set, and a later AB40..AB43 sequence -> pass.
REQ-038 SHALL verify reset mid-run: wb_rst_i pulsed at cp_index=2 -> all outputs 0 the next cycle; re-running the full sequence -> pass.
REQ-039 SHALL verify enable drop: enable low in PASS -> IDLE and pass=0; enable high again -> elapsed restarts from 0.
